// File: rtl/traffic_phase_ctrl.sv
// Two-way intersection phase sequencer: walks green/yellow/all-red ring, inserts a
// pedestrian WALK phase on request, and times each phase through an external countdown timer.
module traffic_phase_ctrl #(
    parameter int T_GREEN  = 20,
    parameter int T_YELLOW = 4,
    parameter int T_ALLRED = 2,
    parameter int T_WALK   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hold,
    input  logic       ped_req,
    input  logic       tmr_done,
    output logic       tmr_start,
    output logic [7:0] tmr_duration,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        S_START = 3'd0,
        S_AR1   = 3'd1,
        S_NSG   = 3'd2,
        S_NSY   = 3'd3,
        S_AR2   = 3'd4,
        S_EWG   = 3'd5,
        S_EWY   = 3'd6,
        S_WALK  = 3'd7
    } state_t;

    function automatic logic [7:0] clamp_dur(input int t);
        if (t <= 0)
            return 8'd1;
        else if (t > 255)
            return 8'd255;
        else
            return 8'(t);
    endfunction

    localparam logic [7:0] D_GREEN  = clamp_dur(T_GREEN);
    localparam logic [7:0] D_YELLOW = clamp_dur(T_YELLOW);
    localparam logic [7:0] D_ALLRED = clamp_dur(T_ALLRED);
    localparam logic [7:0] D_WALK   = clamp_dur(T_WALK);

    function automatic logic [7:0] dur_of(input state_t s);
        case (s)
            S_NSG, S_EWG: return D_GREEN;
            S_NSY, S_EWY: return D_YELLOW;
            S_WALK:       return D_WALK;
            default:      return D_ALLRED;
        endcase
    endfunction

    // Packed as {ns[2:0], ew[2:0], walk}; each lamp triple is {red,yellow,green}.
    function automatic logic [6:0] lamps_of(input state_t s);
        case (s)
            S_NSG:   return 7'b001_100_0;
            S_NSY:   return 7'b010_100_0;
            S_EWG:   return 7'b100_001_0;
            S_EWY:   return 7'b100_010_0;
            S_WALK:  return 7'b100_100_1;
            default: return 7'b100_100_0;
        endcase
    endfunction

    state_t     r_state;
    logic       r_ped_pending;
    logic       r_next_dir;     // 0: NSG follows WALK, 1: EWG follows WALK
    logic [2:0] r_ns;
    logic [2:0] r_ew;
    logic       r_walk;

    state_t     w_next;
    logic       w_next_dir;
    logic       w_adv;
    logic       w_go;
    logic       w_to_walk;
    logic       w_ped;

    assign w_ped     = r_ped_pending | ped_req;
    assign w_adv     = tmr_done & ~hold & (r_state != S_START);
    assign w_go      = w_adv | (r_state == S_START);
    assign w_to_walk = w_go & (w_next == S_WALK);

    always_comb begin
        w_next     = r_state;
        w_next_dir = r_next_dir;
        case (r_state)
            S_START: w_next = S_AR1;
            S_AR1: begin
                if (w_ped) begin
                    w_next     = S_WALK;
                    w_next_dir = 1'b0;
                end else begin
                    w_next = S_NSG;
                end
            end
            S_NSG:   w_next = S_NSY;
            S_NSY:   w_next = S_AR2;
            S_AR2: begin
                if (w_ped) begin
                    w_next     = S_WALK;
                    w_next_dir = 1'b1;
                end else begin
                    w_next = S_EWG;
                end
            end
            S_EWG:   w_next = S_EWY;
            S_EWY:   w_next = S_AR1;
            S_WALK:  w_next = r_next_dir ? S_EWG : S_NSG;
            default: w_next = S_START;
        endcase
    end

    // Duration is presented for the upcoming phase on the advancing edge so the
    // timer reloads exactly when the state changes.
    assign tmr_start    = ~hold;
    assign tmr_duration = dur_of(w_go ? w_next : r_state);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_START;
            r_ped_pending <= 1'b0;
            r_next_dir    <= 1'b0;
            r_ns          <= 3'b100;
            r_ew          <= 3'b100;
            r_walk        <= 1'b0;
        end else begin
            if (w_go) begin
                r_state                <= w_next;
                r_next_dir             <= w_next_dir;
                {r_ns, r_ew, r_walk}   <= lamps_of(w_next);
            end
            if (w_to_walk)
                r_ped_pending <= 1'b0;
            else if (ped_req && (r_state != S_WALK))
                r_ped_pending <= 1'b1;
        end
    end

    assign ns_light = r_ns;
    assign ew_light = r_ew;
    assign walk     = r_walk;
    assign phase    = r_state;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: includes the countdown timer, a ring dwell table,
// hand-written corner sequences and a randomized run against a dwell-based model.
module tb_traffic_phase_ctrl;

    localparam int TG = 5;
    localparam int TY = 2;
    localparam int TA = 1;
    localparam int TW = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       hold;
    logic       ped_req;
    logic       t_done;
    logic [7:0] t_cnt;
    logic       tmr_start;
    logic [7:0] tmr_duration;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       walk;
    logic [2:0] phase;
    logic [6:0] obs;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    traffic_phase_ctrl #(
        .T_GREEN (TG),
        .T_YELLOW(TY),
        .T_ALLRED(TA),
        .T_WALK  (TW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .hold        (hold),
        .ped_req     (ped_req),
        .tmr_done    (t_done),
        .tmr_start   (tmr_start),
        .tmr_duration(tmr_duration),
        .ns_light    (ns_light),
        .ew_light    (ew_light),
        .walk        (walk),
        .phase       (phase)
    );

    // Countdown timer used by the controller.
    always_ff @(posedge clk) begin
        if (rst) begin
            t_cnt  <= 8'd0;
            t_done <= 1'b0;
        end else if (tmr_start) begin
            if (t_cnt == 8'd0) begin
                t_cnt  <= tmr_duration;
                t_done <= 1'b0;
            end else begin
                t_cnt <= t_cnt - 8'd1;
                if (t_cnt == 8'd1)
                    t_done <= 1'b1;
            end
        end
    end

    assign obs = {ns_light, ew_light, walk};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] lamps(input int p);
        case (p)
            2:       return 7'b001_100_0;
            3:       return 7'b010_100_0;
            5:       return 7'b100_001_0;
            6:       return 7'b100_010_0;
            7:       return 7'b100_100_1;
            default: return 7'b100_100_0;
        endcase
    endfunction

    function automatic int mdwell(input int p);
        case (p)
            1, 4:    return TA + 1;
            2, 5:    return TG + 1;
            3, 6:    return TY + 1;
            7:       return TW + 1;
            default: return 1;
        endcase
    endfunction

    task automatic expect_phase(input string name, input int p, input int dwell);
        int n;
        check({name, " phase"}, int'(phase), p);
        check({name, " lamps"}, int'(obs), int'(lamps(p)));
        n = 0;
        while (int'(phase) == p && n < 200) begin
            n++;
            tick();
        end
        check({name, " dwell"}, n, dwell);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        hold = 1'b0;
        ped_req = 1'b0;
        tick();
        tick();
    endtask

    typedef struct {
        int         ph;
        int         dwell;
        logic [6:0] lmp;
    } vec_t;

    vec_t ring[8];

    int mph, mrem, nx;
    logic mpend, mdir, madv;
    int saved_cnt;

    initial begin
        ring[0] = '{0, 1, 7'b100_100_0};
        ring[1] = '{1, 2, 7'b100_100_0};
        ring[2] = '{2, 6, 7'b001_100_0};
        ring[3] = '{3, 3, 7'b010_100_0};
        ring[4] = '{4, 2, 7'b100_100_0};
        ring[5] = '{5, 6, 7'b100_001_0};
        ring[6] = '{6, 3, 7'b100_010_0};
        ring[7] = '{1, 2, 7'b100_100_0};

        // Reset state
        do_reset();
        check("rst phase", int'(phase), 0);
        check("rst ns", int'(ns_light), 4);
        check("rst ew", int'(ew_light), 4);
        check("rst walk", int'(walk), 0);
        check("rst dur", int'(tmr_duration), TA);
        check("rst start", int'(tmr_start), 1);
        rst = 1'b0;

        // Plain ring from reset
        for (int i = 0; i < 8; i++) begin
            int n;
            check("ring phase", int'(phase), ring[i].ph);
            check("ring lamps", int'(obs), int'(ring[i].lmp));
            n = 0;
            while (int'(phase) == ring[i].ph && n < 200) begin
                n++;
                tick();
            end
            check("ring dwell", n, ring[i].dwell);
        end

        // Pedestrian pulse during NSG, served after AR2
        ped_req = 1'b1;
        check("ped nsg phase", int'(phase), 2);
        tick();
        ped_req = 1'b0;
        expect_phase("ped nsg", 2, 5);
        expect_phase("ped nsy", 3, 3);
        expect_phase("ped ar2", 4, 2);
        expect_phase("ped walk", 7, 4);
        expect_phase("ped ewg", 5, 6);
        expect_phase("ped ewy", 6, 3);
        expect_phase("ped ar1", 1, 2);
        expect_phase("ped cleared nsg", 2, 6);

        // Request arriving exactly on the AR1 done cycle
        expect_phase("late nsy", 3, 3);
        expect_phase("late ar2", 4, 2);
        expect_phase("late ewg", 5, 6);
        expect_phase("late ewy", 6, 3);
        check("late ar1 c1", int'(phase), 1);
        tick();
        check("late ar1 c2", int'(phase), 1);
        check("late ar1 done", int'(t_done), 1);
        ped_req = 1'b1;
        tick();
        ped_req = 1'b0;
        expect_phase("late walk", 7, 4);
        expect_phase("late nsg", 2, 6);

        // Hold for 7 cycles mid-NSG
        expect_phase("h nsy", 3, 3);
        expect_phase("h ar2", 4, 2);
        expect_phase("h ewg", 5, 6);
        expect_phase("h ewy", 6, 3);
        expect_phase("h ar1", 1, 2);
        tick();
        tick();
        saved_cnt = int'(t_cnt);
        check("hold cnt before", saved_cnt, 3);
        hold = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("hold phase", int'(phase), 2);
            check("hold ns", int'(ns_light), 1);
            check("hold cnt", int'(t_cnt), saved_cnt);
        end
        hold = 1'b0;
        expect_phase("hold nsg rest", 2, 4);

        // Hold asserted while done is already high in NSY
        tick();
        tick();
        check("nsy done", int'(t_done), 1);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("nsy held", int'(phase), 3);
        end
        hold = 1'b0;
        tick();
        check("nsy release", int'(phase), 4);
        expect_phase("post ar2", 4, 2);

        // Reset during EWG discards a pending request
        tick();
        check("rst ewg", int'(phase), 5);
        ped_req = 1'b1;
        tick();
        ped_req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst phase", int'(phase), 0);
        check("midrst lamps", int'(obs), int'(7'b100_100_0));
        check("midrst cnt", int'(t_cnt), 0);
        expect_phase("midrst start", 0, 1);
        expect_phase("midrst ar1", 1, 2);
        expect_phase("midrst nsg", 2, 6);

        // Randomized run against a dwell-counting model
        do_reset();
        rst = 1'b0;
        mph = 0;
        mrem = 0;
        mpend = 1'b0;
        mdir = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            check("rand out", int'({phase, obs}), int'({3'(mph), lamps(mph)}));
            ped_req = ($urandom_range(15) == 0);
            hold = (mph != 0) && ($urandom_range(7) == 0);
            madv = 1'b0;
            nx = mph;
            if (mph == 0) begin
                madv = 1'b1;
                nx = 1;
            end else if (!hold) begin
                mrem--;
                if (mrem == 0) begin
                    madv = 1'b1;
                    case (mph)
                        1: nx = (mpend || ped_req) ? 7 : 2;
                        4: nx = (mpend || ped_req) ? 7 : 5;
                        7: nx = mdir ? 5 : 2;
                        6: nx = 1;
                        default: nx = mph + 1;
                    endcase
                end
            end
            if (madv && nx == 7) begin
                mdir = (mph == 4);
                mpend = 1'b0;
            end else if (ped_req && mph != 7) begin
                mpend = 1'b1;
            end
            if (madv) begin
                mph = nx;
                mrem = mdwell(nx);
            end
            tick();
        end
        ped_req = 1'b0;
        hold = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
